// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit cells.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One decimal counter digit: counts 0..9 on inc and wraps to 0; at_max flags the value 9.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == BCD_MAX) ? '0 : q + 1'b1;
        end
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch run control: start/stop/clear/lap FSM, tick prescaler and a rippled chain of
// BCD digits with a sticky overflow flag and a lap capture register.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        clear,
    input  logic                        lap,
    output logic [BCD_W*NUM_DIGITS-1:0] count,
    output logic [BCD_W*NUM_DIGITS-1:0] lap_value,
    output logic                        running,
    output logic                        overflow
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t                state;
    logic [PW-1:0]         prescaler;
    logic                  tick;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] inc;
    logic                  all_max;

    assign tick    = (state == RUN) && (prescaler == PRE_LAST);
    assign all_max = &at_max;

    // Digit k advances only when every lower digit is about to wrap.
    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            if (k == 0) begin : g_lsd
                assign inc[k] = tick;
            end else begin : g_upper
                assign inc[k] = inc[k-1] & at_max[k-1];
            end

            bcd_digit u_digit (
                .clk     (clk),
                .reset_n (reset_n),
                .clr     (clear),
                .inc     (inc[k]),
                .q       (count[BCD_W*k +: BCD_W]),
                .at_max  (at_max[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prescaler <= '0;
            running   <= 1'b0;
            overflow  <= 1'b0;
            lap_value <= '0;
        end else if (clear) begin
            state     <= IDLE;
            prescaler <= '0;
            running   <= 1'b0;
            overflow  <= 1'b0;
            lap_value <= '0;
        end else begin
            // Captures the pre-increment count of this same edge.
            if (lap) begin
                lap_value <= count;
            end
            if (tick && all_max) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    prescaler <= tick ? '0 : prescaler + 1'b1;
                    if (stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    // Prescaler holds so a resumed run finishes the partial period.
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    prescaler <= '0;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench: two stopwatch instances (fast 2-digit, slow 4-digit) share random strobes
// and are compared each cycle against an integer-valued reference model.
module tb_bcd_stopwatch_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;
    logic lap = 1'b0;

    logic [7:0]  count_a, lap_a;
    logic        run_a, ovf_a;
    logic [15:0] count_b, lap_b;
    logic        run_b, ovf_b;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.NUM_DIGITS(2), .TICK_DIV(1)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .lap       (lap),
        .count     (count_a),
        .lap_value (lap_a),
        .running   (run_a),
        .overflow  (ovf_a)
    );

    bcd_stopwatch_ctrl #(.NUM_DIGITS(4), .TICK_DIV(3)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .lap       (lap),
        .count     (count_b),
        .lap_value (lap_b),
        .running   (run_b),
        .overflow  (ovf_b)
    );

    typedef struct {
        logic [15:0] ca;
        logic [15:0] la;
        logic        ra;
        logic        oa;
        logic [15:0] cb;
        logic [15:0] lb;
        logic        rb;
        logic        ob;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: count kept as a plain integer modulo 10^digits.
    int m_state[2];
    int m_cnt[2];
    int m_pre[2];
    int m_lap[2];
    int m_ovf[2];
    int m_div[2] = '{1, 3};
    int m_mod[2] = '{100, 10000};

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_IDLE;
            m_cnt[i]   = 0;
            m_pre[i]   = 0;
            m_lap[i]   = 0;
            m_ovf[i]   = 0;
        end
    endfunction

    function automatic void model_step(int i, bit st, bit sp, bit cl, bit lp);
        bit tick;
        tick = (m_state[i] == M_RUN) && (m_pre[i] == m_div[i] - 1);
        if (cl) begin
            m_state[i] = M_IDLE;
            m_cnt[i]   = 0;
            m_pre[i]   = 0;
            m_lap[i]   = 0;
            m_ovf[i]   = 0;
        end else begin
            if (lp) m_lap[i] = m_cnt[i];
            if (tick) begin
                m_pre[i] = 0;
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == m_mod[i]) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 1;
                end
            end else if (m_state[i] == M_RUN) begin
                m_pre[i] = m_pre[i] + 1;
            end
            if (m_state[i] == M_RUN && sp) m_state[i] = M_PAUSE;
            else if (m_state[i] != M_RUN && st) m_state[i] = M_RUN;
        end
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit st, bit sp, bit cl, bit lp);
        exp_t e;
        @(negedge clk);
        start = st;
        stop  = sp;
        clear = cl;
        lap   = lp;
        model_step(0, st, sp, cl, lp);
        model_step(1, st, sp, cl, lp);
        e.ca = to_bcd(m_cnt[0]);
        e.la = to_bcd(m_lap[0]);
        e.ra = (m_state[0] == M_RUN);
        e.oa = (m_ovf[0] != 0);
        e.cb = to_bcd(m_cnt[1]);
        e.lb = to_bcd(m_lap[1]);
        e.rb = (m_state[1] == M_RUN);
        e.ob = (m_ovf[1] != 0);
        sb.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(string tag);
        check({tag, " count_a"}, {8'h0, count_a}, 16'h0);
        check({tag, " lap_a"}, {8'h0, lap_a}, 16'h0);
        check({tag, " run_a"}, {15'h0, run_a}, 16'h0);
        check({tag, " ovf_a"}, {15'h0, ovf_a}, 16'h0);
        check({tag, " count_b"}, count_b, 16'h0);
        check({tag, " lap_b"}, lap_b, 16'h0);
        check({tag, " run_b"}, {15'h0, run_b}, 16'h0);
        check({tag, " ovf_b"}, {15'h0, ovf_b}, 16'h0);
    endtask

    // Asserts reset between edges and checks the outputs clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count_a", {8'h0, count_a}, e.ca);
            check("lap_a", {8'h0, lap_a}, e.la);
            check("run_a", {15'h0, run_a}, {15'h0, e.ra});
            check("ovf_a", {15'h0, ovf_a}, {15'h0, e.oa});
            check("count_b", count_b, e.cb);
            check("lap_b", lap_b, e.lb);
            check("run_b", {15'h0, run_b}, {15'h0, e.rb});
            check("ovf_b", {15'h0, ovf_b}, {15'h0, e.ob});
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 check_zero("power_on");
        @(negedge clk);
        reset_n = 1'b1;

        // Start, run, stop/hold, resume.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(15);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(20);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Lap while running, then lap while paused.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // start+stop from PAUSE resumes; start+stop in RUN pauses; ignored strobes.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(7);

        // clear+start+lap during RUN.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Long run wraps the 4-digit instance through all-9s.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(30005);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Random strobes.
        for (int n = 0; n < 4000; n++) begin
            step(($urandom % 8) == 0, ($urandom % 12) == 0, ($urandom % 150) == 0,
                 ($urandom % 8) == 0);
        end

        // Mid-run async reset; counting needs a fresh start afterwards.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(130);
        async_reset();
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Run-control block for a chain of BCD counter digits. It holds start/stop/clear/lap control, a prescaler that generates count ticks, and ripple-enable sequencing across NUM_DIGITS decimal digits. It sits between the user push-button/strobe logic and the 7-segment display path, and drives the packed BCD count and a captured lap value.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits; digit 0 is least significant.
TICK_DIV, 10, clk cycles per count tick while running; legal range >= 1.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle strobe; enter or resume RUN.
stop  input  1  single-cycle strobe; RUN -> PAUSE.
clear  input  1  single-cycle strobe; zero everything, go to IDLE.
lap  input  1  single-cycle strobe; capture the current count.
count  output  4*NUM_DIGITS  packed BCD count; digit k occupies bits [4k+3:4k].
lap_value  output  4*NUM_DIGITS  last captured count, same packing.
running  output  1  high while the FSM is in RUN.
overflow  output  1  sticky; set on wrap from all-9s to all-0s.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; all digits 0; prescaler 0; count=0, lap_value=0, running=0, overflow=0. Takes effect immediately, including mid-run.
- FSM states: IDLE, RUN, PAUSE. Strobe priority is clear > stop > start.
- clear, from any state: next state IDLE; digits, prescaler, lap_value and overflow go to 0.
- start: IDLE or PAUSE -> RUN. start is ignored in RUN.
- stop: RUN -> PAUSE. stop is ignored in IDLE and PAUSE.
- start and stop in the same cycle: stop wins if in RUN. Otherwise start is taken.
- running is registered: it equals (state==RUN) and changes on the edge where the state changes.
- Prescaler: counts only in RUN, from 0 to TICK_DIV-1. tick = (state==RUN) && (prescaler==TICK_DIV-1); the prescaler wraps to 0 on tick.
- Prescaler holds its value in PAUSE, so a resumed run completes the partial tick period. It is zeroed in IDLE.
- With TICK_DIV=1, tick is asserted on every RUN cycle.
- Digit sequencing: digit 0 increments on tick. Digit k increments on tick when digits 0..k-1 all equal 9.
- An incrementing digit at 9 goes to 0. Digit values are never outside 0..9.
- Latency: count reflects a tick on the clock edge that samples the tick (registered output, no extra stage).
- Overflow: a tick with all digits at 9 wraps count to all zeros and sets overflow. overflow stays 1 until clear or reset; counting continues.
- Lap: lap in any state (unless clear is asserted) loads lap_value with the count value before that same edge's increment. lap_value holds until the next lap, clear or reset.
- Simultaneous events:
  - clear with lap: clear wins and lap_value becomes 0.
  - stop on a tick cycle: the tick is applied, then the FSM enters PAUSE.
  - start from IDLE: the first tick comes TICK_DIV cycles after entry to RUN.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum {IDLE, RUN, PAUSE};
  - constant BCD_MAX = 4'd9;
  - digit width constant BCD_W = 4.
- One sub-module, bcd_digit, generated NUM_DIGITS times.
  - Ports: clk, reset_n, clr, inc, q[3:0], at_max.
  - Behaviour: q goes 0..9 and wraps on inc; at_max = (q==9).
  - The controller chains the at_max outputs into the inc enables.

Test Plan:
1. TICK_DIV=1; reset, start, 10 cycles in RUN -> count=0x0010, running=1, overflow=0.
2. TICK_DIV=3; start, wait 15 cycles -> count=0x0005. stop, idle 20 cycles -> count stays 0x0005, running=0. start, 3 cycles -> count=0x0006.
3. TICK_DIV=1; run 9999 ticks -> count=0x9999. One more tick -> count=0x0000, overflow=1. clear -> overflow=0, FSM IDLE.
4. TICK_DIV=1; lap pulsed when count=0x0037 -> lap_value=0x0037 while count advances to 0x0038. lap in PAUSE at 0x0050 -> lap_value=0x0050.
5. Strobe collisions:
   - clear+start+lap in the same cycle during RUN at 0x0123 -> next cycle IDLE, count=0, lap_value=0, running=0.
   - start+stop in the same cycle from PAUSE -> RUN.
6. reset_n low asynchronously, mid-cycle during RUN at 0x0042 -> all outputs 0 before the next clk edge. After release, start is required to resume counting.
